stage_sequencer: RTL

Multi-cycle control FSM that steps the core through its seven stages: FETCH, FETCH_WAIT, DECODE, EXECUTE, MEMORY, MEMORY_WAIT, WRITEBACK. It drives the per-stage strobes that gate the program counter, register file and memory interfaces. It owns the instruction-memory and data-memory request handshakes, halt/fault detection, and the cycle and retired-instruction performance counters.

---
 rtl/stage_sequencer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/stage_sequencer.sv
// Multi-cycle stage controller: sequences FETCH..WRITEBACK, owns the imem/dmem
// request handshakes, halt/bus-fault detection and the cycle/retired counters.
module stage_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   run,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    input  logic                   is_mem_op,
    input  logic                   is_halt,
    output logic [2:0]             stage,
    output logic                   is_fetch_stage,
    output logic                   is_decode_stage,
    output logic                   is_execute_stage,
    output logic                   is_memory_stage,
    output logic                   is_writeback_stage,
    output logic                   imem_req,
    output logic                   dmem_req,
    output logic                   halted,
    output logic                   bus_fault,
    output logic [COUNT_WIDTH-1:0] cycle_count,
    output logic [COUNT_WIDTH-1:0] retired_count
);

    // Wait counter only needs to reach MEM_TIMEOUT-1 before the fault fires.
    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam logic [WAIT_W-1:0] LAST_WAIT =
        (MEM_TIMEOUT == 0) ? '0 : WAIT_W'(MEM_TIMEOUT - 1);

    // HALTED and FAULT share encoding 7; the sticky flags tell them apart.
    typedef enum logic [2:0] {
        ST_FETCH       = 3'd0,
        ST_FETCH_WAIT  = 3'd1,
        ST_DECODE      = 3'd2,
        ST_EXECUTE     = 3'd3,
        ST_MEMORY      = 3'd4,
        ST_MEMORY_WAIT = 3'd5,
        ST_WRITEBACK   = 3'd6,
        ST_STOPPED     = 3'd7
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                   halted_q, halted_d;
    logic                   bus_fault_q, bus_fault_d;
    logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
    logic [COUNT_WIDTH-1:0] retired_q, retired_d;
    logic                   timeout_hit;

    assign timeout_hit = TIMEOUT_EN && (wait_cnt_q == LAST_WAIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            wait_cnt_q  <= '0;
            halted_q    <= 1'b0;
            bus_fault_q <= 1'b0;
            cycle_q     <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            halted_q    <= halted_d;
            bus_fault_q <= bus_fault_d;
            cycle_q     <= cycle_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        halted_d    = halted_q;
        bus_fault_d = bus_fault_q;

        case (state_q)
            ST_FETCH: begin
                if (run) begin
                    state_d    = ST_FETCH_WAIT;
                    wait_cnt_d = '0;
                end
            end
            ST_FETCH_WAIT: begin
                // Ready on the final allowed wait cycle still wins over the fault.
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout_hit) begin
                    state_d     = ST_STOPPED;
                    bus_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_DECODE: begin
                if (is_halt) begin
                    state_d  = ST_STOPPED;
                    halted_d = 1'b1;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = is_mem_op ? ST_MEMORY : ST_WRITEBACK;
            end
            ST_MEMORY: begin
                state_d    = ST_MEMORY_WAIT;
                wait_cnt_d = '0;
            end
            ST_MEMORY_WAIT: begin
                if (dmem_ready) begin
                    state_d = ST_WRITEBACK;
                end else if (timeout_hit) begin
                    state_d     = ST_STOPPED;
                    bus_fault_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
            end
            default: begin
                state_d = ST_STOPPED;
            end
        endcase
    end

    // The cycle that enters the terminal state still counts; the terminal state does not.
    always_comb begin
        cycle_d   = cycle_q;
        retired_d = retired_q;
        if (state_q != ST_STOPPED) begin
            cycle_d = cycle_q + COUNT_WIDTH'(1);
        end
        if (state_q == ST_WRITEBACK) begin
            retired_d = retired_q + COUNT_WIDTH'(1);
        end
    end

    // Strobes are forced low while reset is held, regardless of the registered state.
    always_comb begin
        is_fetch_stage     = !reset && (state_q == ST_FETCH);
        is_decode_stage    = !reset && (state_q == ST_DECODE);
        is_execute_stage   = !reset && (state_q == ST_EXECUTE);
        is_memory_stage    = !reset && (state_q == ST_MEMORY);
        is_writeback_stage = !reset && (state_q == ST_WRITEBACK);
        imem_req           = !reset && (state_q == ST_FETCH) && run;
        dmem_req           = !reset && (state_q == ST_MEMORY);
    end

    assign stage         = state_q;
    assign halted        = halted_q;
    assign bus_fault     = bus_fault_q;
    assign cycle_count   = cycle_q;
    assign retired_count = retired_q;

endmodule
